// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the execute-stage RV32M multiply/divide unit.
//   - funct3 encodings of the M-extension ops
//   - FSM state encoding
//   - default datapath width and the architectural special-case constants
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // Quotient returned for a zero divisor, and the most negative value
  // (the only dividend that overflows when divided by -1).
  localparam logic [XLEN_DEF-1:0] DIV_BY_ZERO_Q = '1;
  localparam logic [XLEN_DEF-1:0] SIGNED_MIN    = {1'b1, {(XLEN_DEF-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: restoring divider datapath, one quotient bit per step.
//   clk, reset  : clock, synchronous active-high reset
//   load        : capture operands (magnitudes for signed ops), clear remainder
//   step        : perform one shift-subtract iteration
//   is_signed   : operands are two's complement (DIV/REM)
//   dividend,
//   divisor     : raw operands, sampled on load
//   quotient,
//   remainder   : sign-corrected results, with divide-by-zero and signed
//                 overflow forced to their architectural values
module muldiv_div_core import muldiv_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN-1:0] dvd_q, dvs_q, dvs_abs, quo, rem;
  logic            sgn_q;
  logic [XLEN:0]   rem_sh, diff;
  logic            q_neg, r_neg, dz, ovf;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic s);
    return (s && x[XLEN-1]) ? -x : x;
  endfunction

  // quo starts out holding the dividend magnitude; its MSB is shifted into
  // the partial remainder each step while quotient bits fill in from the LSB.
  assign rem_sh = {rem, quo[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs_abs};

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q   <= '0;
      dvs_q   <= '0;
      dvs_abs <= '0;
      sgn_q   <= 1'b0;
      quo     <= '0;
      rem     <= '0;
    end else if (load) begin
      dvd_q   <= dividend;
      dvs_q   <= divisor;
      sgn_q   <= is_signed;
      dvs_abs <= mag(divisor, is_signed);
      quo     <= mag(dividend, is_signed);
      rem     <= '0;
    end else if (step) begin
      if (diff[XLEN]) begin
        rem <= rem_sh[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end else begin
        rem <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end
    end
  end

  assign q_neg = sgn_q & (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
  assign r_neg = sgn_q & dvd_q[XLEN-1];
  assign dz    = (dvs_q == '0);
  assign ovf   = sgn_q && (dvd_q == SMIN) && (dvs_q == '1);

  always_comb begin
    quotient  = q_neg ? -quo : quo;
    remainder = r_neg ? -rem : rem;
    if (dz) begin
      quotient  = '1;
      remainder = dvd_q;
    end else if (ovf) begin
      quotient  = SMIN;
      remainder = '0;
    end
  end

endmodule

// File: rtl/execute_muldiv_unit.sv
// execute_muldiv_unit: RV32M multiply/divide engine in the Execute stage.
//   clk, reset   : clock, synchronous active-high reset
//   StartE       : execute-stage instruction is an M op
//   MulDivOpE    : funct3 of the op
//   SrcAE, SrcBE : forwarded rs1 / rs2
//   RdE          : destination register
//   FlushE       : execute flush; abandons any op in flight
//   StallReqE    : stall request to the hazard unit (combinational)
//   DoneE        : one-cycle result-valid pulse
//   ResultE      : result, held after completion
//   RdMDE        : destination of the completed op
// Optional build macro MULDIV_SPECIAL_FASTPATH_EN: divide-by-zero and signed
// overflow complete in one cycle instead of running the full divider.
module execute_muldiv_unit import muldiv_pkg::*; #(
  parameter int XLEN       = XLEN_DEF,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic [2:0]      MulDivOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic [4:0]      RdE,
  input  logic            FlushE,
  output logic            StallReqE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE,
  output logic [4:0]      RdMDE
);

  localparam int             CW      = $clog2(XLEN+1);
  localparam logic [CW-1:0]  MUL_CNT = CW'(MUL_STAGES-1);
  localparam logic [CW-1:0]  DIV_CNT = CW'(XLEN);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q, res_q;
  logic [4:0]        rd_q, rdmd_q;
  logic              accept, special_in, div_load, div_step;
  logic [XLEN-1:0]   div_q, div_r, mul_res, live_res;
  logic              a_sx, b_sx;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;

  assign accept   = (state == IDLE) && StartE && !FlushE && !reset;
  assign div_load = accept && MulDivOpE[2];

`ifdef MULDIV_SPECIAL_FASTPATH_EN
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  assign special_in = MulDivOpE[2] &&
                      ((SrcBE == '0) || (!MulDivOpE[0] && (SrcAE == SMIN) && (SrcBE == '1)));
`else
  assign special_in = 1'b0;
`endif

  // The count is the number of busy cycles left; the op moves to DONE on the
  // cycle that uses up the last one, so a zero load skips the busy state.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    div_step = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (MulDivOpE[2]) begin
          if (special_in) state_nx = DONE;
          else begin
            state_nx = DIV;
            cnt_nx   = DIV_CNT;
          end
        end else if (MUL_CNT == '0) begin
          state_nx = DONE;
        end else begin
          state_nx = MUL;
          cnt_nx   = MUL_CNT;
        end
      end
      MUL: if (FlushE) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) state_nx = DONE;
      end
      DIV: if (FlushE) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end else begin
        div_step = 1'b1;
        cnt_nx   = cnt - CW'(1);
        if (cnt == CW'(1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      res_q  <= '0;
      rdmd_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        op_q <= MulDivOpE;
        a_q  <= SrcAE;
        b_q  <= SrcBE;
        rd_q <= RdE;
      end
      if (DoneE) begin
        res_q  <= live_res;
        rdmd_q <= rd_q;
      end
    end
  end

  muldiv_div_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .is_signed (!MulDivOpE[0]),
    .dividend  (SrcAE),
    .divisor   (SrcBE),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // rs1 is signed for MUL/MULH/MULHSU, rs2 only for MUL/MULH; the low half
  // of a product of sign-extended operands is the exact 2*XLEN result.
  assign a_sx  = (op_q[1:0] != 2'b11) & a_q[XLEN-1];
  assign b_sx  = !op_q[1] & b_q[XLEN-1];
  assign a_ext = {{XLEN{a_sx}}, a_q};
  assign b_ext = {{XLEN{b_sx}}, b_q};
  assign prod  = a_ext * b_ext;

  assign mul_res  = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign live_res = op_q[2] ? (op_q[1] ? div_r : div_q) : mul_res;

  // A flush in DONE suppresses the pulse and leaves the held result alone.
  assign DoneE     = (state == DONE) && !FlushE;
  assign ResultE   = DoneE ? live_res : res_q;
  assign RdMDE     = DoneE ? rd_q : rdmd_q;
  assign StallReqE = accept || (state == MUL) || (state == DIV);

endmodule

// File: tb/tb_execute_muldiv_unit.sv
module tb_execute_muldiv_unit;
  import muldiv_pkg::*;

  localparam int MS = 2;
`ifdef MULDIV_SPECIAL_FASTPATH_EN
  localparam int SPL = 1;
`else
  localparam int SPL = 33;
`endif
  localparam int DL = 33;

  logic        clk = 1'b0;
  logic        reset, StartE, FlushE;
  logic [2:0]  MulDivOpE;
  logic [31:0] SrcAE, SrcBE;
  logic [4:0]  RdE;
  logic        StallReqE, DoneE;
  logic [31:0] ResultE;
  logic [4:0]  RdMDE;

  int checks = 0;
  int errors = 0;

  execute_muldiv_unit #(.XLEN(32), .MUL_STAGES(MS)) dut (
    .clk(clk), .reset(reset), .StartE(StartE), .MulDivOpE(MulDivOpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .RdE(RdE), .FlushE(FlushE),
    .StallReqE(StallReqE), .DoneE(DoneE), .ResultE(ResultE), .RdMDE(RdMDE)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called #1 after the accept edge; returns cycles until DoneE (accept = 0)
  // and how many of the cycles in between requested a stall.
  task automatic wait_done(output int lat, output int busy);
    lat  = 1;
    busy = 0;
    while (!DoneE && lat < 200) begin
      if (StallReqE) busy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output int busy);
    @(negedge clk);
    StartE = 1'b1; MulDivOpE = op; SrcAE = a; SrcBE = b; RdE = rd;
    #1;
    chk("stall_on_accept", {31'b0, StallReqE}, 32'd1);
    @(posedge clk); #1;
    // scramble the live inputs: only the latched copies may matter now
    StartE = 1'b0; SrcAE = ~a; SrcBE = 32'h5a5a_1234; MulDivOpE = ~op; RdE = ~rd;
    wait_done(lat, busy);
  endtask

  int lat, busy, ndone;

  initial begin
    vecs[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, MS};
    vecs[1]  = '{OP_MULH,   32'h80000000, 32'h80000000, 5'd2,  32'h40000000, MS};
    vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, MS};
    vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, MS};
    vecs[4]  = '{OP_MUL,    32'h12345678, 32'h10,       5'd5,  32'h23456780, MS};
    vecs[5]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, DL};
    vecs[6]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, DL};
    vecs[7]  = '{OP_DIVU,   32'd5,        32'd0,        5'd8,  32'hFFFFFFFF, SPL};
    vecs[8]  = '{OP_REMU,   32'd5,        32'd0,        5'd9,  32'd5,        SPL};
    vecs[9]  = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, SPL};
    vecs[10] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0,        SPL};
    vecs[11] = '{OP_REM,    32'hFFFFFFFB, 32'd0,        5'd12, 32'hFFFFFFFB, SPL};
    vecs[12] = '{OP_DIVU,   32'd100,      32'd7,        5'd13, 32'd14,       DL};
    vecs[13] = '{OP_REMU,   32'd100,      32'd7,        5'd14, 32'd2,        DL};
    vecs[14] = '{OP_DIV,    32'd7,        32'hFFFFFFFE, 5'd15, 32'hFFFFFFFD, DL};
    vecs[15] = '{OP_REM,    32'd7,        32'hFFFFFFFE, 5'd16, 32'd1,        DL};

    reset = 1'b1; StartE = 1'b0; FlushE = 1'b0;
    MulDivOpE = '0; SrcAE = '0; SrcBE = '0; RdE = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", ResultE, 32'd0);
    chk("reset_rd", {27'b0, RdMDE}, 32'd0);
    chk("reset_done", {31'b0, DoneE}, 32'd0);
    chk("reset_stall", {31'b0, StallReqE}, 32'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, lat, busy);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy_stall", i), busy, vecs[i].lat - 1);
      chk($sformatf("v%0d_stall_at_done", i), {31'b0, StallReqE}, 32'd0);
      chk($sformatf("v%0d_result", i), ResultE, vecs[i].exp);
      chk($sformatf("v%0d_rd", i), {27'b0, RdMDE}, {27'b0, vecs[i].rd});
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), {31'b0, DoneE}, 32'd0);
      chk($sformatf("v%0d_result_held", i), ResultE, vecs[i].exp);
    end

    // Flush ten cycles into a divide: abandoned, old result kept.
    @(negedge clk);
    StartE = 1'b1; MulDivOpE = OP_DIVU; SrcAE = 32'd100; SrcBE = 32'd7; RdE = 5'd20;
    @(posedge clk); #1;
    StartE = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    FlushE = 1'b1;
    @(posedge clk); #1;
    FlushE = 1'b0;
    chk("flush_stall", {31'b0, StallReqE}, 32'd0);
    chk("flush_done", {31'b0, DoneE}, 32'd0);
    chk("flush_result_kept", ResultE, vecs[NV-1].exp);
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (DoneE) ndone++; end
    chk("flush_no_done", ndone, 0);
    run_op(OP_MUL, 32'd3, 32'd4, 5'd9, lat, busy);
    chk("post_flush_latency", lat, MS);
    chk("post_flush_result", ResultE, 32'd12);
    chk("post_flush_rd", {27'b0, RdMDE}, 32'd9);

    // Reset in the middle of a divide, then a start held across release.
    @(negedge clk);
    StartE = 1'b1; MulDivOpE = OP_DIV; SrcAE = 32'd100; SrcBE = 32'd7; RdE = 5'd21;
    @(posedge clk); #1;
    StartE = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_result", ResultE, 32'd0);
    chk("midreset_rd", {27'b0, RdMDE}, 32'd0);
    chk("midreset_done", {31'b0, DoneE}, 32'd0);
    chk("midreset_stall", {31'b0, StallReqE}, 32'd0);
    StartE = 1'b1; MulDivOpE = OP_MUL; SrcAE = 32'd5; SrcBE = 32'd6; RdE = 5'd7;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    StartE = 1'b0;
    wait_done(lat, busy);
    chk("rel_latency", lat, MS);
    chk("rel_result", ResultE, 32'd30);
    chk("rel_rd", {27'b0, RdMDE}, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_muldiv_unit.md
Name: execute_muldiv_unit

Overview:
RV32M multiply/divide engine in the Execute stage, directly downstream of the decode-to-execute pipeline register. It takes the forwarded operands, the decoded funct3 and the destination register, and runs MUL* over a fixed number of cycles and DIV*/REM* as an iterative restoring divider. While an operation runs it raises a stall request to the hazard unit. The result goes to the execute result mux, then into the execute-to-memory register.

Parameters:
XLEN, 32, operand/result width; the divider iterates XLEN times.
MUL_STAGES, 2, cycles from accepted start to DoneE for MUL*; legal range 1..4.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
StartE  input  1  execute-stage instruction is an M-extension op
MulDivOpE  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcAE  input  XLEN  forwarded rs1 value
SrcBE  input  XLEN  forwarded rs2 value
RdE  input  5  destination register of the execute instruction
FlushE  input  1  execute-stage flush from the hazard unit
StallReqE  output  1  combinational; stall F/D/E stages
DoneE  output  1  result valid this cycle (one-cycle pulse)
ResultE  output  XLEN  operation result, held until the next accepted start
RdMDE  output  5  destination of the completed op

Behaviour:
- Clock, reset: one clock (clk); reset is synchronous and active-high. Reset has priority over FlushE and StartE.
- Reset values: state IDLE, ResultE=0, RdMDE=0, DoneE=0, counter=0, StallReqE=0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - StartE=1 and FlushE=0: latch operands, op and RdE at the edge.
  - MulDivOpE[2]=0 goes to MUL with count=MUL_STAGES-1.
  - MulDivOpE[2]=1 goes to DIV with count=XLEN.
  - Special case (see Optional Feature) goes to DONE.
- MUL:
  - Full 2*XLEN product formed from sign/zero-extended operands: MULHSU treats rs1 as signed and rs2 as unsigned.
  - Decrement each cycle; at count 0, go to DONE.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- DIV:
  - Signed ops divide absolute values.
  - One quotient bit per cycle (restoring shift-subtract); after XLEN iterations, go to DONE.
  - Quotient is negated when operand signs differ; remainder takes the dividend's sign.
- DONE: DoneE=1 and ResultE/RdMDE valid; next state is always IDLE. StartE is ignored here because the same instruction is still leaving E.
- StallReqE = (state==IDLE && StartE && !FlushE) || state==MUL || state==DIV. It is low in DONE so the pipeline advances with the result.
- Latency from the start-accept edge to DoneE:
  - MUL*: MUL_STAGES cycles.
  - DIV*/REM*: XLEN+1 cycles.
  - Special cases: 1 cycle.
- Divide by zero: quotient = all ones for both DIV and DIVU; remainder = dividend.
- Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
- FlushE in MUL/DIV/DONE: next state IDLE, no DoneE, ResultE keeps its prior value. FlushE together with StartE in IDLE: start not accepted.
- StartE is ignored while in MUL/DIV. Operands are taken only from the latched copies, so SrcAE/SrcBE changes mid-op have no effect.

Optional Feature:
Macro MULDIV_SPECIAL_FASTPATH_EN.
- Defined: divide-by-zero and signed overflow are detected in IDLE and go straight to DONE (latency 1).
- Undefined: these cases run the full XLEN+1-cycle DIV path and then override the result with the same architectural values.
- Results are identical in both builds; only latency differs.

Decomposition:
- Package muldiv_pkg holds:
  - funct3 op encodings;
  - FSM state enum;
  - XLEN default;
  - DIV_BY_ZERO_Q (all ones) and SIGNED_MIN (0x80000000) constants.
- One sub-module, muldiv_div_core: restoring divider datapath (remainder/quotient shift registers, iteration step, sign fix-up). The FSM, counter and stall logic stay in the top module.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3), MUL_STAGES=2 -> DoneE exactly 2 cycles after accept, ResultE=0xFFFFFFEB; StallReqE high for 2 cycles and low on the DoneE cycle.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD, DoneE at 33 cycles; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0. Latency is 1 with MULDIV_SPECIAL_FASTPATH_EN and 33 without.
- FlushE asserted 10 cycles into a DIV -> IDLE next cycle, no DoneE, ResultE unchanged; a following MUL 3×4 -> 12 with correct RdMDE.
- reset asserted mid-DIV -> all outputs zero the next cycle, state IDLE; StartE held through reset release -> op accepted on the first non-reset edge.
